// File: rtl/ascii_pkg.sv
// ascii_pkg: shared ASCII constants and the occupancy state type used by the
// streaming case converters.
//   ASCII_UPPER_A/Z, ASCII_LOWER_A/Z : inclusive letter ranges
//   CASE_BIT                         : the bit that separates upper from lower case
//   occ_t                            : occupancy of the output register + skid entry
//   in_range()                       : inclusive byte range test
package ascii_pkg;

  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam int         CASE_BIT      = 5;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } occ_t;

  function automatic logic in_range(input logic [7:0] b,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/ascii_case_conv.sv
// ascii_case_conv: combinational single-byte ASCII case converter.
//   in[7:0]   byte to convert
//   to_lower  1 = map 'A'..'Z' to lower case, 0 = map 'a'..'z' to upper case
//   en        0 = pass every byte through unchanged
//   out[7:0]  converted byte
//   changed   1 = out differs from in
// Only the exact letter ranges are touched; bytes with bit 7 set never match.
module ascii_case_conv
  import ascii_pkg::*;
(
  input  logic [7:0] in,
  input  logic       to_lower,
  input  logic       en,
  output logic [7:0] out,
  output logic       changed
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    out     = in;
    changed = 1'b0;
    if (en) begin
      if (to_lower && in_range(in, ASCII_UPPER_A, ASCII_UPPER_Z)) begin
        out[CASE_BIT] = 1'b1;
        changed       = 1'b1;
      end else if (!to_lower && in_range(in, ASCII_LOWER_A, ASCII_LOWER_Z)) begin
        out[CASE_BIT] = 1'b0;
        changed       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tolower_stream.sv
// tolower_stream: streaming ASCII upper-to-lower case converter between two
// valid/ready links. Output is registered and backed by one skid entry, so
// in_ready depends only on local state (never on out_ready).
//   clk, rst_n            clock, synchronous active-low reset
//   en                    convert (1) or pass through (0), taken per byte at accept
//   clr_counts            synchronous clear of both statistics counters
//   in_valid/in_data/in_ready     producer link
//   out_valid/out_data/out_conv/out_ready  consumer link; out_conv marks a modified byte
//   conv_count, byte_count         saturating counts of delivered bytes
module tolower_stream
  import ascii_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_counts,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_conv,
  input  logic             out_ready,
  output logic [CNT_W-1:0] conv_count,
  output logic [CNT_W-1:0] byte_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  occ_t       occ;
  logic       accept;
  logic       deliver;
  logic [7:0] conv_data;
  logic       conv_flag;
  logic [7:0] skid_data;
  logic       skid_conv;

  // Conversion happens on the way in, so buffered bytes keep the en value
  // that applied when they were accepted.
  ascii_case_conv u_conv (
    .in       (in_data),
    .to_lower (1'b1),
    .en       (en),
    .out      (conv_data),
    .changed  (conv_flag)
  );

  // Held low during reset so nothing is accepted into a buffer being cleared.
  assign in_ready = rst_n && (occ != TWO);
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  // Occupancy FSM with the output register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge regardless of statement order.
    if (!rst_n) begin
      occ       <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_conv  <= 1'b0;
    end else begin
      case (occ)
        EMPTY: begin
          if (accept) begin
            out_data  <= conv_data;
            out_conv  <= conv_flag;
            out_valid <= 1'b1;
            occ       <= ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            // New byte replaces the one just delivered.
            out_data <= conv_data;
            out_conv <= conv_flag;
          end else if (accept) begin
            occ <= TWO;
          end else if (deliver) begin
            out_valid <= 1'b0;
            occ       <= EMPTY;
          end
        end
        TWO: begin
          if (deliver) begin
            out_data <= skid_data;
            out_conv <= skid_conv;
            occ      <= ONE;
          end
        end
        default: begin
          occ       <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the skid entry has no reset; it is only read in TWO, and reset
  // forces EMPTY, so stale contents can never be delivered.
  always_ff @(posedge clk) begin
    if (occ == ONE && accept && !deliver) begin
      skid_data <= conv_data;
      skid_conv <= conv_flag;
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_counts) begin
      byte_count <= '0;
      conv_count <= '0;
    end else if (deliver) begin
      if (byte_count != CNT_MAX) begin
        byte_count <= byte_count + CNT_ONE;
      end
      if (out_conv && conv_count != CNT_MAX) begin
        conv_count <= conv_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_tolower_stream.sv
// tb_tolower_stream: self-checking bench for tolower_stream. A 2-deep FIFO
// model with saturating counters predicts every cycle; a second instance with
// 4-bit counters shares the same stimulus to exercise saturation.
module tb_tolower_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr_counts;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        in_ready,  in_ready4;
  logic        out_valid, out_valid4;
  logic [7:0]  out_data,  out_data4;
  logic        out_conv,  out_conv4;
  logic [15:0] conv_count, byte_count;
  logic [3:0]  conv_count4, byte_count4;

  always #5 clk = ~clk;

  tolower_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_counts(clr_counts),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_conv(out_conv),
    .out_ready(out_ready), .conv_count(conv_count), .byte_count(byte_count)
  );

  tolower_stream #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_counts(clr_counts),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_conv(out_conv4),
    .out_ready(out_ready), .conv_count(conv_count4), .byte_count(byte_count4)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] d;
    logic       c;
  } item_t;

  item_t q[$];
  int    m_b16, m_c16, m_b4, m_c4;
  bit    last_accept;
  int    checks   = 0;
  int    failures = 0;

  function automatic item_t ref_lower(input logic [7:0] d, input logic e);
    item_t it;
    int    v = int'(d);
    if (e && v >= 65 && v <= 90) begin
      it.d = 8'(v + 32);
      it.c = 1'b1;
    end else begin
      it.d = d;
      it.c = 1'b0;
    end
    return it;
  endfunction

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    logic exp_rdy;
    logic exp_vld;
    exp_rdy = rst_n && (q.size() < 2);
    exp_vld = (q.size() > 0);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_vld);
    check("in_ready4", in_ready4, exp_rdy);
    check("out_valid4", out_valid4, exp_vld);
    if (exp_vld) begin
      check("out_data", out_data, q[0].d);
      check("out_conv", out_conv, q[0].c);
      check("out_data4", out_data4, q[0].d);
    end
    check("byte_count", byte_count, m_b16);
    check("conv_count", conv_count, m_c16);
    check("byte_count4", byte_count4, m_b4);
    check("conv_count4", conv_count4, m_c4);
  endtask

  task automatic model_update();
    bit    acc;
    bit    del;
    item_t it;
    if (!rst_n) begin
      q.delete();
      m_b16 = 0; m_c16 = 0; m_b4 = 0; m_c4 = 0;
      last_accept = 1'b0;
      return;
    end
    acc = in_valid && (q.size() < 2);
    del = out_ready && (q.size() > 0);
    if (del) begin
      it = q.pop_front();
      m_b16 = sat_inc(m_b16, 65535);
      m_b4  = sat_inc(m_b4, 15);
      if (it.c) begin
        m_c16 = sat_inc(m_c16, 65535);
        m_c4  = sat_inc(m_c4, 15);
      end
    end
    if (clr_counts) begin
      m_b16 = 0; m_c16 = 0; m_b4 = 0; m_c4 = 0;
    end
    if (acc) q.push_back(ref_lower(in_data, en));
    last_accept = acc;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0] din;
    logic       en;
    logic [7:0] dout;
    logic       conv;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int conv_run;
    int deliv;
    int drops;

    vecs[0] = '{8'h41, 1'b1, 8'h61, 1'b1};
    vecs[1] = '{8'h40, 1'b1, 8'h40, 1'b0};
    vecs[2] = '{8'h5B, 1'b1, 8'h5B, 1'b0};
    vecs[3] = '{8'h61, 1'b1, 8'h61, 1'b0};
    vecs[4] = '{8'hC1, 1'b1, 8'hC1, 1'b0};
    vecs[5] = '{8'h41, 1'b0, 8'h41, 1'b0};
    vecs[6] = '{8'h5A, 1'b1, 8'h7A, 1'b1};
    vecs[7] = '{8'h7B, 1'b1, 8'h7B, 1'b0};

    rst_n = 1'b0; en = 1'b1; clr_counts = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    q.delete();
    m_b16 = 0; m_c16 = 0; m_b4 = 0; m_c4 = 0;
    last_accept = 1'b1;

    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    sample();
    check("rst out_valid", out_valid, 1'b0);
    check("rst out_data", out_data, 8'h00);
    check("rst out_conv", out_conv, 1'b0);
    check("rst in_ready", in_ready, 1'b0);
    check("rst byte_count", byte_count, 16'd0);
    check("rst conv_count", conv_count, 16'd0);
    advance();
    rst_n = 1'b1;

    // Single bytes into EMPTY, one at a time.
    out_ready = 1'b1;
    conv_run  = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[i].din;
      en       = vecs[i].en;
      tick();
      in_valid = 1'b0;
      en       = 1'b1;
      sample();
      check("vec out_valid", out_valid, 1'b1);
      check("vec out_data", out_data, vecs[i].dout);
      check("vec out_conv", out_conv, vecs[i].conv);
      advance();
      if (vecs[i].conv) conv_run++;
      sample();
      check("vec byte_count", byte_count, 32'(i + 1));
      check("vec conv_count", conv_count, 32'(conv_run));
      advance();
    end

    // Back-pressure fills to TWO, then drains in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h42;
    tick();
    in_data   = 8'h43;
    tick();
    in_valid  = 1'b0;
    sample();
    check("full in_ready", in_ready, 1'b0);
    check("full head", out_data, 8'h62);
    advance();
    out_ready = 1'b1;
    sample();
    check("drain first", out_data, 8'h62);
    advance();
    sample();
    check("drain second", out_data, 8'h63);
    check("drain in_ready", in_ready, 1'b1);
    advance();
    sample();
    check("drain empty", out_valid, 1'b0);
    advance();

    // Full throughput streaming of 'Z'.
    deliv = 0;
    drops = 0;
    in_data = 8'h5A;
    for (int i = 0; i < 101; i++) begin
      in_valid = (i < 100);
      sample();
      if (i < 100 && !in_ready) drops++;
      if (out_valid && out_ready) deliv++;
      advance();
    end
    check("stream deliveries", deliv, 100);
    check("stream ready drops", drops, 0);

    // Saturation with 4-bit counters, then clear racing a deliver.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h41 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    sample();
    check("sat byte_count4", byte_count4, 4'hF);
    check("sat conv_count4", conv_count4, 4'hF);
    check("sat byte_count", byte_count, 16'd20);
    advance();
    in_valid = 1'b1;
    in_data  = 8'h42;
    tick();
    in_valid = 1'b0;
    sample();
    check("clr setup valid", out_valid, 1'b1);
    clr_counts = 1'b1;
    advance();
    clr_counts = 1'b0;
    sample();
    check("clr byte_count", byte_count, 16'd0);
    check("clr conv_count", conv_count, 16'd0);
    check("clr byte_count4", byte_count4, 4'd0);
    check("clr conv_count4", conv_count4, 4'd0);
    advance();

    // Reset while holding two bytes.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h44;
    tick();
    in_data   = 8'h45;
    tick();
    out_ready = 1'b1;
    tick();                       // one delivery so counters are non-zero
    out_ready = 1'b0;
    in_data   = 8'h46;
    tick();
    rst_n = 1'b0;
    sample();
    check("mid-rst in_ready", in_ready, 1'b0);
    advance();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    sample();
    check("post-rst out_valid", out_valid, 1'b0);
    check("post-rst out_data", out_data, 8'h00);
    check("post-rst byte_count", byte_count, 16'd0);
    check("post-rst in_ready", in_ready, 1'b1);
    advance();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Randomized traffic against the model.
    last_accept = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !last_accept)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: in_data = 8'h41 + 8'($urandom_range(0, 25));
          1: in_data = ($urandom_range(0, 1) != 0) ? 8'h40 : 8'h5B;
          2: in_data = 8'h61 + 8'($urandom_range(0, 25));
          default: in_data = 8'($urandom_range(0, 255));
        endcase
      end
      en         = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      clr_counts = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid   = 1'b0;
    clr_counts = 1'b0;
    out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
